// File: rtl/vend_if.sv
// Handshake bundle between the vending sequencer and its coin, select,
// dispense and payout partners.
interface vend_if;
    logic [1:0] coin;
    logic       coin_valid;
    logic [1:0] sel;
    logic       sel_valid;
    logic       cancel;
    logic       disp_req;
    logic [1:0] disp_prod;
    logic       disp_ack;
    logic       chg_req;
    logic [1:0] chg_coin;
    logic       chg_ack;
    logic [7:0] credit;
    logic       reject;
    logic       busy;

    modport master (
        output coin, coin_valid, sel, sel_valid, cancel, disp_ack, chg_ack,
        input  disp_req, disp_prod, chg_req, chg_coin, credit, reject, busy
    );

    modport slave (
        input  coin, coin_valid, sel, sel_valid, cancel, disp_ack, chg_ack,
        output disp_req, disp_prod, chg_req, chg_coin, credit, reject, busy
    );
endinterface

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: accumulates coin credit, dispenses a selected
// product, pays change one coin at a time and auto-refunds after inactivity.
module vend_sequencer #(
    parameter int unsigned PRICE0     = 15,
    parameter int unsigned PRICE1     = 20,
    parameter int unsigned PRICE2     = 25,
    parameter int unsigned PRICE3     = 30,
    parameter int unsigned MAX_CREDIT = 50,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic   clk,
    input  logic   rst,
    vend_if.slave  bus
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [CW-1:0]   idle_q, idle_d;
    logic            disp_req_q, disp_req_d;
    logic [1:0]      disp_prod_q, disp_prod_d;
    logic            chg_req_q, chg_req_d;
    logic [1:0]      chg_coin_q, chg_coin_d;
    logic            reject_q, reject_d;
    logic            busy_q, busy_d;

    logic [CW-1:0]   coin_amt_c;
    logic [CW:0]     coin_sum_c;
    logic            coin_ok_c;
    logic [CW-1:0]   post_credit_c;
    logic [CW-1:0]   price_c;
    logic [CW-1:0]   paid_amt_c;
    logic [CW-1:0]   remain_c;
    logic [CW-1:0]   idle_inc_c;

    // Largest coin that still fits in the remaining credit.
    function automatic logic [1:0] pay_coin(input logic [CW-1:0] c);
        return (c >= CW'(10)) ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        coin_amt_c = '0;
        case (bus.coin)
            2'b01:   coin_amt_c = CW'(5);
            2'b10:   coin_amt_c = CW'(10);
            default: coin_amt_c = '0;
        endcase
    end

    always_comb begin
        price_c = CW'(PRICE0);
        case (bus.sel)
            2'd0: price_c = CW'(PRICE0);
            2'd1: price_c = CW'(PRICE1);
            2'd2: price_c = CW'(PRICE2);
            2'd3: price_c = CW'(PRICE3);
            default: price_c = CW'(PRICE0);
        endcase
    end

    // Sum is one bit wider so a ceiling near 255 cannot wrap into acceptance.
    assign coin_sum_c    = {1'b0, credit_q} + {1'b0, coin_amt_c};
    assign coin_ok_c     = bus.coin_valid && (coin_amt_c != '0) &&
                           (coin_sum_c <= (CW+1)'(MAX_CREDIT));
    assign post_credit_c = coin_ok_c ? coin_sum_c[CW-1:0] : credit_q;
    assign paid_amt_c    = (chg_coin_q == 2'b10) ? CW'(10) : CW'(5);
    assign remain_c      = (credit_q >= paid_amt_c) ? (credit_q - paid_amt_c) : '0;
    assign idle_inc_c    = idle_q + CW'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        idle_d      = '0;
        disp_req_d  = disp_req_q;
        disp_prod_d = disp_prod_q;
        chg_req_d   = chg_req_q;
        chg_coin_d  = chg_coin_q;
        reject_d    = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                reject_d = bus.coin_valid && !coin_ok_c;
                credit_d = post_credit_c;
                if (bus.cancel && (post_credit_c != '0)) begin
                    state_d    = CHANGE;
                    chg_req_d  = 1'b1;
                    chg_coin_d = pay_coin(post_credit_c);
                end else if (bus.sel_valid && (post_credit_c >= price_c)) begin
                    state_d     = DISPENSE;
                    credit_d    = post_credit_c - price_c;
                    disp_req_d  = 1'b1;
                    disp_prod_d = bus.sel;
                end else if (post_credit_c == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = CREDIT;
                    // Inactivity refund: only quiet cycles spent in CREDIT count.
                    if ((state_q == CREDIT) && !bus.coin_valid && !bus.sel_valid) begin
                        if (idle_inc_c == CW'(TIMEOUT)) begin
                            state_d    = CHANGE;
                            chg_req_d  = 1'b1;
                            chg_coin_d = pay_coin(post_credit_c);
                        end else begin
                            idle_d = idle_inc_c;
                        end
                    end
                end
            end

            DISPENSE: begin
                reject_d = bus.coin_valid;
                if (disp_req_q && bus.disp_ack) begin
                    disp_req_d  = 1'b0;
                    disp_prod_d = 2'b00;
                    if (credit_q != '0) begin
                        state_d    = CHANGE;
                        chg_req_d  = 1'b1;
                        chg_coin_d = pay_coin(credit_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            CHANGE: begin
                reject_d = bus.coin_valid;
                if (chg_req_q) begin
                    if (bus.chg_ack) begin
                        credit_d   = remain_c;
                        chg_req_d  = 1'b0;
                        chg_coin_d = 2'b00;
                        if (remain_c == '0) begin
                            state_d = IDLE;
                        end
                    end
                end else if (credit_q == '0) begin
                    state_d = IDLE;
                end else begin
                    // One-cycle gap after each paid coin, then request the next.
                    chg_req_d  = 1'b1;
                    chg_coin_d = pay_coin(credit_q);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            idle_q      <= '0;
            disp_req_q  <= 1'b0;
            disp_prod_q <= 2'b00;
            chg_req_q   <= 1'b0;
            chg_coin_q  <= 2'b00;
            reject_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            idle_q      <= idle_d;
            disp_req_q  <= disp_req_d;
            disp_prod_q <= disp_prod_d;
            chg_req_q   <= chg_req_d;
            chg_coin_q  <= chg_coin_d;
            reject_q    <= reject_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.credit    = credit_q;
    assign bus.disp_req  = disp_req_q;
    assign bus.disp_prod = disp_prod_q;
    assign bus.chg_req   = chg_req_q;
    assign bus.chg_coin  = chg_coin_q;
    assign bus.reject    = reject_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level vending model.
module tb_vend_sequencer;

    localparam int MAXC = 50;
    localparam int TMO  = 255;

    int price [4] = '{15, 20, 25, 30};

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    // Reference model: credit in plain integers plus activity flags.
    int m_cr, m_idle, m_dprod, m_ccoin;
    bit m_disp, m_pay, m_dreq, m_preq, m_rej;

    vend_if bus ();

    vend_sequencer #(
        .PRICE0(15), .PRICE1(20), .PRICE2(25), .PRICE3(30),
        .MAX_CREDIT(MAXC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int coinv(input int code);
        if (code == 1) return 5;
        if (code == 2) return 10;
        return 0;
    endfunction

    task automatic model_reset();
        m_cr = 0; m_idle = 0; m_dprod = 0; m_ccoin = 0;
        m_disp = 0; m_pay = 0; m_dreq = 0; m_preq = 0; m_rej = 0;
    endtask

    task automatic start_pay();
        m_pay   = 1;
        m_preq  = 1;
        m_ccoin = (m_cr >= 10) ? 10 : 5;
    endtask

    task automatic model_step(input int coin, input bit cv, input int sel, input bit sv,
                              input bit cancel, input bit dack, input bit cack);
        int c;
        int v;
        bit was_credit;
        m_rej = 0;
        if (m_disp) begin
            if (cv) m_rej = 1;
            if (dack) begin
                m_disp = 0;
                m_dreq = 0;
                if (m_cr > 0) start_pay();
            end
        end else if (m_pay) begin
            if (cv) m_rej = 1;
            if (m_preq) begin
                if (cack) begin
                    m_cr  -= m_ccoin;
                    m_preq = 0;
                    if (m_cr == 0) m_pay = 0;
                end
            end else begin
                m_preq  = 1;
                m_ccoin = (m_cr >= 10) ? 10 : 5;
            end
        end else begin
            was_credit = (m_cr > 0);
            c = m_cr;
            v = coinv(coin);
            if (cv) begin
                if (v != 0 && c + v <= MAXC) c += v;
                else m_rej = 1;
            end
            m_cr = c;
            if (cancel && c > 0) begin
                m_idle = 0;
                start_pay();
            end else if (sv && c >= price[sel]) begin
                m_cr    = c - price[sel];
                m_disp  = 1;
                m_dreq  = 1;
                m_dprod = sel;
                m_idle  = 0;
            end else if (was_credit && c > 0 && !cv && !sv) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_idle = 0;
                    start_pay();
                end
            end else begin
                m_idle = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("credit",   32'(bus.credit),   32'(m_cr));
        chk("disp_req", 32'(bus.disp_req), 32'(m_dreq));
        if (m_dreq) chk("disp_prod", 32'(bus.disp_prod), 32'(m_dprod));
        chk("chg_req",  32'(bus.chg_req),  32'(m_preq));
        if (m_preq) chk("chg_coin", 32'(bus.chg_coin), (m_ccoin == 10) ? 32'd2 : 32'd1);
        chk("reject",   32'(bus.reject),   32'(m_rej));
        chk("busy",     32'(bus.busy),     32'(m_disp || m_pay));
    endtask

    task automatic step(input int coin, input bit cv, input int sel, input bit sv,
                        input bit cancel, input bit dack, input bit cack);
        bus.coin       = 2'(coin);
        bus.coin_valid = cv;
        bus.sel        = 2'(sel);
        bus.sel_valid  = sv;
        bus.cancel     = cancel;
        bus.disp_ack   = dack;
        bus.chg_ack    = cack;
        model_step(coin, cv, sel, sv, cancel, dack, cack);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ins(input int code);
        step(code, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_pay || m_disp) && n < 40) begin
            step(0, 0, 0, 0, 0, 1, 1);
            n++;
        end
        chk("drain_bound", 32'(m_pay || m_disp), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_credit"},    32'(bus.credit),    32'd0);
        chk({tag, "_disp_req"},  32'(bus.disp_req),  32'd0);
        chk({tag, "_disp_prod"}, 32'(bus.disp_prod), 32'd0);
        chk({tag, "_chg_req"},   32'(bus.chg_req),   32'd0);
        chk({tag, "_chg_coin"},  32'(bus.chg_coin),  32'd0);
        chk({tag, "_reject"},    32'(bus.reject),    32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        bus.coin = 2'b00; bus.coin_valid = 1'b0; bus.sel = 2'b00; bus.sel_valid = 1'b0;
        bus.cancel = 1'b0; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
        model_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Coins 10,10,5 then product 1; coin and select during dispense are refused/ignored.
        ins(2); ins(2); ins(1);
        chk("s1_credit25", 32'(bus.credit), 32'd25);
        step(0, 0, 1, 1, 0, 0, 0);
        chk("s1_credit5", 32'(bus.credit), 32'd5);
        chk("s1_disp_prod", 32'(bus.disp_prod), 32'd1);
        step(1, 1, 3, 1, 1, 0, 0);
        chk("s1_rej_busy", 32'(bus.reject), 32'd1);
        idle_step();
        step(0, 0, 0, 0, 0, 1, 0);
        chk("s1_disp_drop", 32'(bus.disp_req), 32'd0);
        chk("s1_coin5", 32'(bus.chg_coin), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("s1_credit0", 32'(bus.credit), 32'd0);
        chk("s1_idle", 32'(bus.busy), 32'd0);

        // Credit 45, extra 10 refused, product 3, change 10 then 5 with a gap.
        ins(2); ins(2); ins(2); ins(2); ins(1);
        ins(2);
        chk("s2_reject", 32'(bus.reject), 32'd1);
        chk("s2_credit45", 32'(bus.credit), 32'd45);
        step(0, 0, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("s2_coin10", 32'(bus.chg_coin), 32'd2);
        idle_step();
        step(0, 0, 0, 0, 0, 0, 1);
        chk("s2_gap", 32'(bus.chg_req), 32'd0);
        chk("s2_credit5", 32'(bus.credit), 32'd5);
        idle_step();
        chk("s2_coin5", 32'(bus.chg_coin), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("s2_credit0", 32'(bus.credit), 32'd0);

        // Coin and cancel together.
        step(1, 1, 0, 0, 1, 0, 0);
        chk("s3_credit5", 32'(bus.credit), 32'd5);
        chk("s3_chg_req", 32'(bus.chg_req), 32'd1);
        drain();

        // Invalid codes and the credit ceiling.
        step(0, 1, 0, 0, 0, 0, 0);
        step(3, 1, 0, 0, 0, 0, 0);
        ins(2); ins(2); ins(2); ins(2); ins(2);
        chk("ceil_credit50", 32'(bus.credit), 32'd50);
        ins(1);
        chk("ceil_reject", 32'(bus.reject), 32'd1);
        step(0, 0, 0, 0, 1, 0, 0);
        drain();

        // Inactivity refund after exactly TIMEOUT quiet cycles.
        ins(2);
        repeat (TMO - 1) idle_step();
        chk("tmo_not_yet", 32'(bus.chg_req), 32'd0);
        idle_step();
        chk("tmo_chg_req", 32'(bus.chg_req), 32'd1);
        chk("tmo_coin10", 32'(bus.chg_coin), 32'd2);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("tmo_credit0", 32'(bus.credit), 32'd0);

        // Reset in the middle of a payout; a pending ack after release is ignored.
        ins(2); ins(2);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("rst_pre_credit", 32'(bus.credit), 32'd20);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        @(negedge clk) rst = 1'b1;
        step(1, 1, 0, 0, 0, 0, 1);
        chk("rst_post_credit", 32'(bus.credit), 32'd5);
        step(0, 0, 0, 0, 1, 0, 0);
        drain();

        // Insufficient credit for product 2.
        ins(2); ins(1); ins(1);
        step(0, 0, 2, 1, 0, 0, 0);
        chk("short_credit20", 32'(bus.credit), 32'd20);
        chk("short_no_disp", 32'(bus.disp_req), 32'd0);
        step(0, 0, 0, 0, 1, 0, 0);
        drain();

        // Random traffic with occasional long quiet stretches.
        for (int blk = 0; blk < 5; blk++) begin
            for (int i = 0; i < 500; i++) begin
                step(int'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 30,
                     int'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 5,
                     $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < 40);
            end
            for (int i = 0; i < 260; i++) begin
                step(0, 0, 0, 0, 0,
                     $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < 40);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameters SHALL be: PRICE0 default 15, price of product 0; PRICE1 default 20; PRICE2 default 25; PRICE3 default 30; MAX_CREDIT default 50, credit ceiling; TIMEOUT default 255, idle cycles before auto-refund.
REQ-002 All PRICEn and MAX_CREDIT SHALL be multiples of 5 and at most 255; PRICEn SHALL NOT exceed MAX_CREDIT.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 coin  in  2  coin code: 01=5, 10=10, 00 and 11 invalid.
REQ-006 coin_valid  in  1  single-cycle strobe qualifying coin.
REQ-007 sel  in  2  product select, 0..3.
REQ-008 sel_valid  in  1  single-cycle strobe qualifying sel.
REQ-009 cancel  in  1  single-cycle refund request.
REQ-010 disp_req  out  1  dispense request to the mechanism.
REQ-011 disp_prod  out  2  product to dispense; valid while disp_req=1.
REQ-012 disp_ack  in  1  mechanism done; sampled only while disp_req=1.
REQ-013 chg_req  out  1  change-coin request to the payout unit.
REQ-014 chg_coin  out  2  coin to pay, 01=5 or 10=10; valid while chg_req=1.
REQ-015 chg_ack  in  1  coin paid; sampled only while chg_req=1.
REQ-016 credit  out  8  current credit, registered.
REQ-017 reject  out  1  one-cycle pulse when a coin is refused.
REQ-018 busy  out  1  high in DISPENSE or CHANGE.

Function
REQ-019 FSM states SHALL be IDLE (credit=0), CREDIT (credit>0), DISPENSE and CHANGE.
REQ-020 In IDLE/CREDIT, a coin_valid with valid code SHALL add 5 or 10 to credit next cycle if the sum is <= MAX_CREDIT; otherwise credit is unchanged and reject pulses the next cycle.
REQ-021 Invalid coin codes with coin_valid=1, and any coin_valid in DISPENSE or CHANGE, SHALL pulse reject the next cycle with credit unchanged.
REQ-022 Priority in IDLE/CREDIT in the same cycle SHALL be: coin accepted first, then cancel, then selection, each evaluated against the post-coin credit.
REQ-023 cancel with post-coin credit>0 SHALL go to CHANGE; with credit=0 it SHALL have no effect.
REQ-024 sel_valid with credit >= PRICEsel SHALL subtract the price, latch disp_prod=sel and go to DISPENSE with disp_req=1 the next cycle; with insufficient credit the selection SHALL be ignored.
REQ-025 disp_req and disp_prod SHALL hold until disp_ack=1 is sampled; disp_req SHALL be 0 the following cycle.
REQ-026 After disp_ack the FSM SHALL go to CHANGE if credit>0, else to IDLE.
REQ-027 In CHANGE, chg_coin SHALL be 10 when credit>=10, else 5; chg_req SHALL hold with chg_coin stable until chg_ack.
REQ-028 On chg_ack, credit SHALL decrease by the coin value next cycle and chg_req SHALL be low for exactly one cycle, then reassert if credit>0.
REQ-029 When credit reaches 0 in CHANGE, the FSM SHALL return to IDLE.
REQ-030 In CREDIT, an 8-bit idle counter SHALL clear on any coin_valid or sel_valid and otherwise increment; on reaching TIMEOUT the FSM SHALL go to CHANGE.
REQ-031 sel_valid and cancel SHALL be ignored in DISPENSE and CHANGE.
REQ-032 credit SHALL never exceed MAX_CREDIT or underflow; arithmetic SHALL be 8-bit unsigned.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, credit=0, the idle counter to 0, and disp_req, disp_prod, chg_req, chg_coin, reject and busy to 0, including mid-dispense or mid-payout.
REQ-034 After rst rises, the first active edge SHALL accept inputs normally; any pending ack is discarded.

Verification
REQ-035 Coins 10,10,5, then sel=1 -> credit 25 then 5; disp_req with disp_prod=1 held until ack; one chg_coin=01; credit 0; IDLE.
REQ-036 Credit 45, insert 10 -> reject pulse, credit 45; sel=3 -> dispense, then change 10 then 5, with chg_req low one cycle between coins.
REQ-037 Coin 5 and cancel in the same cycle -> credit 5, CHANGE, one 5-coin payout, IDLE.
REQ-038 Credit 10, no activity for 255 cycles -> CHANGE, chg_coin=10, credit 0 after ack.
REQ-039 rst asserted while chg_req=1 with credit 20 -> all outputs 0 at once; coin 5 after release gives credit 5.
REQ-040 sel=2 with credit 20 -> ignored, credit 20, disp_req stays 0.
